regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Register file built on the team's D flip-flop storage element.
- Sits directly downstream of the flip-flop: it consumes flip-flop outputs as register bits.
- Feeds the datapath's ALU operand ports: two registered read ports and one write port.
- Register 0 is optionally hardwired to zero, per the CPU programming model.

Parameters:
- DATA_WIDTH, 32: bits per register.
- ADDR_WIDTH, 5: address bits; the register count is 2**ADDR_WIDTH.
- ZERO_REG, 1: 1 means register 0 always reads 0 and writes to it are discarded; 0 means register 0 is an ordinary register.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  write enable.
- WR_ADDR  in  ADDR_WIDTH  write address.
- WR_DATA  in  DATA_WIDTH  write data.
- RD_EN_A  in  1  port A read request.
- RD_ADDR_A  in  ADDR_WIDTH  port A address.
- RD_DATA_A  out  DATA_WIDTH  port A registered read data.
- RD_VALID_A  out  1  port A data valid, one cycle after request.
- RD_EN_B, RD_ADDR_B, RD_DATA_B, RD_VALID_B: same as port A, for port B.

Behaviour:
- Reset (RST=1, asynchronous, takes effect immediately regardless of CLK):
  - all registers = 0;
  - RD_DATA_A = RD_DATA_B = 0;
  - RD_VALID_A = RD_VALID_B = 0.
  - While RST is held, writes and reads are ignored.
  - A write in flight when RST asserts is lost.
  - First accepted operation is on the first rising CLK after RST deasserts.
- Write: on rising CLK with WR_EN=1, register[WR_ADDR] <= WR_DATA.
  - If ZERO_REG=1 and WR_ADDR=0, the write is discarded.
- Read, per port X in {A, B}: on rising CLK with RD_EN_X=1:
  - RD_DATA_X <= value of register[RD_ADDR_X];
  - RD_VALID_X <= 1.
  - Latency is exactly 1 cycle.
- Read with RD_EN_X=0:
  - RD_VALID_X <= 0;
  - RD_DATA_X holds its previous value (no update).
- Write-to-read bypass: same edge with WR_EN=1, RD_EN_X=1, RD_ADDR_X=WR_ADDR (and not the suppressed zero register):
  - RD_DATA_X <= WR_DATA (write-first semantics).
- Zero register: ZERO_REG=1 and RD_ADDR_X=0 gives RD_DATA_X <= 0, even if a write to 0 is on the same edge.
- Both ports may read the same address on the same edge; both return identical data.
- Ports A and B are fully independent; there is no port priority and no stall.
- All addresses are in range by construction (2**ADDR_WIDTH entries); there is no wrap or out-of-range case.
- No X propagation from storage after reset.
- WR_DATA = X with WR_EN = 0 must not disturb any register.

Decomposition:
- Shared package/header:
  - DATA_WIDTH and ADDR_WIDTH defaults;
  - ZERO_REG_INDEX = 0.
- One natural sub-module: reg_word.
  - DATA_WIDTH-bit register with load enable and asynchronous clear, built from the flip-flop cell.
  - The file instantiates 2**ADDR_WIDTH copies, with one-hot write-enable decode and two read muxes.
- The read output registers may reuse reg_word with load = RD_EN_X.

Test Plan:
1. Reset, then RD_EN_A=1, RD_ADDR_A=7 -> next cycle RD_DATA_A=0x00000000, RD_VALID_A=1.
2. Write 0xDEADBEEF to r5; next cycle RD_EN_A=1 r5 and RD_EN_B=1 r5 -> one cycle later both ports = 0xDEADBEEF, both valids = 1.
3. Same edge: WR_EN=1, WR_ADDR=9, WR_DATA=0x12345678, and RD_EN_B=1 r9 (r9 previously 0x1) -> RD_DATA_B=0x12345678 (bypass).
4. ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 on port A -> 0x00000000. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
5. Read r5 (0xDEADBEEF) on port A, then RD_EN_A=0 for 3 cycles while writing r5=0x0 -> RD_DATA_A stays 0xDEADBEEF, RD_VALID_A=0.
6. Write r3=0xA5A5A5A5, then assert RST mid-cycle (between edges) -> all outputs 0 immediately, without waiting for a CLK edge. After release, a read of r3 returns 0x00000000.

Source files
------------

// File: rtl/regfile_2r1w_pkg.sv
// Shared defaults for the 2-read/1-write register file.
package regfile_2r1w_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int ZERO_REG_INDEX = 0;
endpackage

// File: rtl/regfile_2r1w_if.sv
// Write port and two read ports of the register file.
interface regfile_2r1w_if
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  WR_EN;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  RD_EN_A;
  logic [ADDR_WIDTH-1:0] RD_ADDR_A;
  logic [DATA_WIDTH-1:0] RD_DATA_A;
  logic                  RD_VALID_A;
  logic                  RD_EN_B;
  logic [ADDR_WIDTH-1:0] RD_ADDR_B;
  logic [DATA_WIDTH-1:0] RD_DATA_B;
  logic                  RD_VALID_B;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, RD_EN_A, RD_ADDR_A, RD_EN_B, RD_ADDR_B,
    input  RD_DATA_A, RD_VALID_A, RD_DATA_B, RD_VALID_B
  );
  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, RD_EN_A, RD_ADDR_A, RD_EN_B, RD_ADDR_B,
    output RD_DATA_A, RD_VALID_A, RD_DATA_B, RD_VALID_B
  );
endinterface

// File: rtl/regfile_2r1w_reg_word.sv
// One storage word: load-enabled register with asynchronous clear.
module reg_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] word_d, word_q;

  always_comb begin
    word_d = word_q;
    if (ld) word_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign q = word_q;
endmodule

// File: rtl/regfile_2r1w.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file, two registered read ports with
// write-first bypass and an optional hardwired-zero register 0.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ZERO_REG   = 1
) (
  input  logic            CLK,
  input  logic            RST,
  regfile_2r1w_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_REG_INDEX);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 we_dec;
  logic                             wr_live;
  logic [DATA_WIDTH-1:0]            rd_a_d, rd_b_d, rd_a_q, rd_b_q;
  logic                             vld_a_d, vld_b_d, vld_a_q, vld_b_q;

  // A write to the hardwired zero register is dropped before decode, so it
  // can neither update storage nor feed the bypass path.
  always_comb begin
    wr_live = bus.WR_EN && !(ZERO_REG != 0 && bus.WR_ADDR == ZIDX);
    we_dec  = '0;
    if (wr_live) we_dec[bus.WR_ADDR] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG != 0 && i == ZERO_REG_INDEX) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_reg
      reg_word #(.W(DATA_WIDTH)) u_word (
        .clk (CLK),
        .rst (RST),
        .ld  (we_dec[i]),
        .d   (bus.WR_DATA),
        .q   (regs[i])
      );
    end
  end

  always_comb begin
    rd_a_d = regs[bus.RD_ADDR_A];
    rd_b_d = regs[bus.RD_ADDR_B];
    if (wr_live && bus.RD_ADDR_A == bus.WR_ADDR) rd_a_d = bus.WR_DATA;
    if (wr_live && bus.RD_ADDR_B == bus.WR_ADDR) rd_b_d = bus.WR_DATA;
    vld_a_d = bus.RD_EN_A;
    vld_b_d = bus.RD_EN_B;
  end

  reg_word #(.W(DATA_WIDTH)) u_rd_a (
    .clk (CLK), .rst (RST), .ld (bus.RD_EN_A), .d (rd_a_d), .q (rd_a_q)
  );
  reg_word #(.W(DATA_WIDTH)) u_rd_b (
    .clk (CLK), .rst (RST), .ld (bus.RD_EN_B), .d (rd_b_d), .q (rd_b_q)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
    end else begin
      vld_a_q <= vld_a_d;
      vld_b_q <= vld_b_d;
    end
  end

  assign bus.RD_DATA_A  = rd_a_q;
  assign bus.RD_DATA_B  = rd_b_q;
  assign bus.RD_VALID_A = vld_a_q;
  assign bus.RD_VALID_B = vld_b_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench: dut has register 0 hardwired to zero, dut_nz does not;
// both see identical stimulus.
module tb_regfile_2r1w;
  import regfile_2r1w_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          wr_en, rd_en_a, rd_en_b;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [DW-1:0] wr_data;

  int checks   = 0;
  int failures = 0;

  regfile_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_z ();
  regfile_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_n ();

  assign bus_z.WR_EN = wr_en;     assign bus_n.WR_EN = wr_en;
  assign bus_z.WR_ADDR = wr_addr; assign bus_n.WR_ADDR = wr_addr;
  assign bus_z.WR_DATA = wr_data; assign bus_n.WR_DATA = wr_data;
  assign bus_z.RD_EN_A = rd_en_a; assign bus_n.RD_EN_A = rd_en_a;
  assign bus_z.RD_EN_B = rd_en_b; assign bus_n.RD_EN_B = rd_en_b;
  assign bus_z.RD_ADDR_A = rd_addr_a; assign bus_n.RD_ADDR_A = rd_addr_a;
  assign bus_z.RD_ADDR_B = rd_addr_b; assign bus_n.RD_ADDR_B = rd_addr_b;

  regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .CLK (CLK), .RST (RST), .bus (bus_z)
  );
  regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_nz (
    .CLK (CLK), .RST (RST), .bus (bus_n)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en_a = 0; rd_en_b = 0;
    wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1;
    tick(); tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'h0 || bus_z.RD_DATA_B !== 32'h0 ||
        bus_z.RD_VALID_A !== 1'b0 || bus_z.RD_VALID_B !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got A=%h B=%h va=%b vb=%b want 0", bus_z.RD_DATA_A,
               bus_z.RD_DATA_B, bus_z.RD_VALID_A, bus_z.RD_VALID_B);
    end
    RST = 0;
    rd_en_a = 1; rd_addr_a = 5'd7;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'h0 || bus_z.RD_VALID_A !== 1'b1) begin
      failures++;
      $display("FAIL reset_read_r7: got %h v=%b want 00000000 v=1", bus_z.RD_DATA_A, bus_z.RD_VALID_A);
    end
    idle();
  endtask

  task automatic test_read_both();
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    rd_en_a = 1; rd_addr_a = 5'd5; rd_en_b = 1; rd_addr_b = 5'd5;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'hDEADBEEF || bus_z.RD_VALID_A !== 1'b1) begin
      failures++;
      $display("FAIL read_a_r5: got %h v=%b want deadbeef v=1", bus_z.RD_DATA_A, bus_z.RD_VALID_A);
    end
    checks++;
    if (bus_z.RD_DATA_B !== 32'hDEADBEEF || bus_z.RD_VALID_B !== 1'b1) begin
      failures++;
      $display("FAIL read_b_r5: got %h v=%b want deadbeef v=1", bus_z.RD_DATA_B, bus_z.RD_VALID_B);
    end
    idle();
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 5'd9; wr_data = 32'h1;
    tick();
    wr_data = 32'h12345678;
    rd_en_b = 1; rd_addr_b = 5'd9;
    tick();
    checks++;
    if (bus_z.RD_DATA_B !== 32'h12345678 || bus_z.RD_VALID_B !== 1'b1) begin
      failures++;
      $display("FAIL bypass_b_r9: got %h v=%b want 12345678 v=1", bus_z.RD_DATA_B, bus_z.RD_VALID_B);
    end
    checks++;
    if (bus_z.RD_VALID_A !== 1'b0) begin
      failures++;
      $display("FAIL bypass_a_idle: got v=%b want 0", bus_z.RD_VALID_A);
    end
    // X on write data with the enable low must leave storage alone
    idle();
    wr_addr = 5'd9; wr_data = 'x;
    tick();
    rd_en_a = 1; rd_addr_a = 5'd9;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'h12345678) begin
      failures++;
      $display("FAIL xdata_no_write: got %h want 12345678", bus_z.RD_DATA_A);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    idle();
    rd_en_a = 1; rd_addr_a = 5'd0;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'h0) begin
      failures++;
      $display("FAIL zero_reg_read: got %h want 00000000", bus_z.RD_DATA_A);
    end
    checks++;
    if (bus_n.RD_DATA_A !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL nonzero_r0_read: got %h want ffffffff", bus_n.RD_DATA_A);
    end
    // same-edge write and read of r0
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'h00000011;
    rd_en_b = 1; rd_addr_b = 5'd0;
    tick();
    checks++;
    if (bus_z.RD_DATA_B !== 32'h0) begin
      failures++;
      $display("FAIL zero_reg_bypass: got %h want 00000000", bus_z.RD_DATA_B);
    end
    checks++;
    if (bus_n.RD_DATA_B !== 32'h00000011) begin
      failures++;
      $display("FAIL nonzero_r0_bypass: got %h want 00000011", bus_n.RD_DATA_B);
    end
    idle();
  endtask

  task automatic test_hold();
    rd_en_a = 1; rd_addr_a = 5'd5;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'hDEADBEEF || bus_z.RD_VALID_A !== 1'b1) begin
      failures++;
      $display("FAIL hold_first_read: got %h v=%b want deadbeef v=1", bus_z.RD_DATA_A, bus_z.RD_VALID_A);
    end
    rd_en_a = 0;
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_z.RD_DATA_A !== 32'hDEADBEEF || bus_z.RD_VALID_A !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got %h v=%b want deadbeef v=0", i, bus_z.RD_DATA_A, bus_z.RD_VALID_A);
      end
    end
    idle();
    rd_en_a = 1; rd_addr_a = 5'd5;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'h0) begin
      failures++;
      $display("FAIL hold_reread_r5: got %h want 00000000", bus_z.RD_DATA_A);
    end
    idle();
  endtask

  task automatic test_async_reset();
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    tick();
    idle();
    rd_en_a = 1; rd_addr_a = 5'd3; rd_en_b = 1; rd_addr_b = 5'd3;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'hA5A5A5A5 || bus_z.RD_DATA_B !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL pre_reset_r3: got A=%h B=%h want a5a5a5a5", bus_z.RD_DATA_A, bus_z.RD_DATA_B);
    end
    // assert reset mid-cycle, well away from any rising edge
    #2;
    RST = 1;
    #1;
    checks++;
    if (bus_z.RD_DATA_A !== 32'h0 || bus_z.RD_DATA_B !== 32'h0 ||
        bus_z.RD_VALID_A !== 1'b0 || bus_z.RD_VALID_B !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got A=%h B=%h va=%b vb=%b want 0", bus_z.RD_DATA_A,
               bus_z.RD_DATA_B, bus_z.RD_VALID_A, bus_z.RD_VALID_B);
    end
    tick();
    RST = 0;
    tick();
    checks++;
    if (bus_z.RD_DATA_A !== 32'h0 || bus_z.RD_VALID_A !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_r3: got %h v=%b want 00000000 v=1", bus_z.RD_DATA_A, bus_z.RD_VALID_A);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_read_both();
    test_bypass();
    test_zero_reg();
    test_hold();
    test_async_reset();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
